dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported, byte-addressed, big-endian 128-byte data memory between requester 0 (CPU load/store unit) and requester 1 (debug/loader port). It accepts 16-bit word transactions through a req/ack handshake and grants simultaneous requests round-robin. It drives the memory's address, write-data and write/read strobes, range-checks every access, and returns registered read data. It sits between the CPU datapath and the data memory instance.

## Interface
Parameters:
- `MEM_BYTES`, 128: memory size in bytes. The last legal word address is `MEM_BYTES-2`.

Ports:
- `Clock`, input, 1: single clock. All state changes on posedge.
- `Reset`, input, 1: synchronous, active-high.
- `req0` / `req1`, input, 1 each: transaction request. Held high with stable `we`/`addr`/`wdata` until `ack` is seen.
- `we0` / `we1`, input, 1 each: 1 = word write, 0 = word read.
- `addr0` / `addr1`, input, 16 each: byte address of the high byte. Odd addresses are legal.
- `wdata0` / `wdata1`, input, 16 each: write word.
- `ack0` / `ack1`, output, 1 each: one-cycle completion pulse.
- `err0` / `err1`, output, 1 each: out-of-range flag. Valid only while the matching `ack` is high.
- `rdata`, output, 16: read word. Valid while either `ack` is high.
- `mem_Address`, output, 16: address to the memory.
- `mem_WriteData`, output, 16: write data to the memory.
- `mem_MemWrite`, output, 1: memory write strobe.
- `mem_MemRead`, output, 1: memory read strobe.
- `mem_ReadData`, input, 16: combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last (`last_gnt` register, reset value 1, so port 0 wins first).
  - On grant: latch `we`, `addr`, `wdata` and the port id; update `last_gnt`; go to ACCESS.
- ACCESS (exactly one cycle):
  - In range (`addr <= MEM_BYTES-2`): drive `mem_Address` = latched addr. If write, `mem_WriteData` = latched wdata and `mem_MemWrite` = 1. If read, `mem_MemRead` = 1.
  - Out of range: both strobes stay 0 and no memory write occurs.
  - At the closing edge:
    - `rdata` ← `mem_ReadData` for an in-range read.
    - `rdata` ← 0 for writes and for out-of-range accesses.
    - Set `ack` and `err` of the granted port.
    - Go to RESP.
- RESP (one cycle): `ack`/`err` high. The next edge clears them and returns to IDLE.
- Memory-side outputs are 0 outside ACCESS: `mem_Address` = 0, `mem_WriteData` = 0, both strobes = 0.
- Address check uses the full 16 bits. Addresses ≥ `MEM_BYTES-1` (127 and above by default) set `err`. There is no wrap-around.
- Byte order is the memory's: `addr` holds `data[15:8]` and `addr+1` holds `data[7:0]`. The arbiter passes words through unchanged.
- Requester rule: after seeing `ack`, drop `req` by the following cycle, or present a new transaction. A `req` still high in the first IDLE cycle is treated as a new transaction.

## Timing
- Reset values: `ack0`, `ack1`, `err0`, `err1` = 0; `rdata` = 0; all `mem_*` outputs = 0; state = IDLE; `last_gnt` = 1.
- Latency: `req` high at IDLE edge E0 → memory driven during E0–E1 → write committed at E1 → `ack` high during E1–E2.
- Throughput: one transaction per 3 cycles. Under continuous contention the ports alternate.
- Starvation bound: a waiting port is granted within at most 6 cycles.
- Simultaneous read-after-write from the other port: serialized. The read observes the committed write.
- `Reset` asserted at E1 while in ACCESS:
  - The memory itself still commits a write strobed during that cycle (the memory is not reset).
  - `ack`/`err`/`rdata` are forced to 0 and the state goes to IDLE.
  - The requester must reissue.
- `Reset` asserted in RESP: `ack` is cleared at that edge.
- Requests arriving while in ACCESS or RESP are not sampled until IDLE.

## Test plan
- Reset, then port 0 write 0xABCD to 0x0010 → `mem_MemWrite`=1 for exactly one cycle with address 0x0010; `ack0` 2 cycles after grant edge; `err0`=0; memory bytes [0x10]=0xAB, [0x11]=0xCD.
- Port 1 read 0x0010 after that write → `ack1` pulse with `rdata`=0xABCD. Then port 0 read at odd address 0x0011 (with [0x12]=0x5A preloaded) → `rdata`=0xCD5A.
- `req0` and `req1` held high together for 12 cycles → grants in order 0,1,0,1; each `ack` is a 1-cycle pulse spaced 3 cycles apart; `ack0` and `ack1` never high together.
- Port 1 write to 0x007F, then to 0x0100 → `err1`=1 with `ack1` each time; `mem_MemWrite` never asserted; `rdata`=0; memory unchanged.
- `Reset` asserted on the ACCESS edge of a port 0 read → no `ack0`; all outputs 0 on the next cycle; state back in IDLE; a reissued read then completes normally.
- Idle bus (no requests for 10 cycles) → all `mem_*` outputs stay 0 and no `ack` is issued.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported 128-byte data memory between the
// CPU load/store unit (port 0) and the debug/loader port (port 1).
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata,
    output logic [15:0] mem_Address,
    output logic [15:0] mem_WriteData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [15:0] mem_ReadData
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [15:0] LastWord = 16'(MEM_BYTES - 2);

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [15:0] rdata_q, rdata_d;
    logic        in_range;
    logic        gnt1;

    // Full 16-bit compare: no wrap-around of high addresses into the memory.
    assign in_range = (addr_q <= LastWord);
    // On contention the port not granted last wins.
    assign gnt1     = req1 & (~req0 | ~last_gnt_q);

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        port_d        = port_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rdata_d       = 16'h0000;
        mem_Address   = 16'h0000;
        mem_WriteData = 16'h0000;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    port_d     = gnt1;
                    last_gnt_d = gnt1;
                    we_d       = gnt1 ? we1 : we0;
                    addr_d     = gnt1 ? addr1 : addr0;
                    wdata_d    = gnt1 ? wdata1 : wdata0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (in_range) begin
                    mem_Address = addr_q;
                    if (we_q) begin
                        mem_WriteData = wdata_q;
                        mem_MemWrite  = 1'b1;
                    end else begin
                        mem_MemRead = 1'b1;
                    end
                end
                rdata_d = (in_range && !we_q) ? mem_ReadData : 16'h0000;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                err0_d  = ~port_q & ~in_range;
                err1_d  = port_q & ~in_range;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign err0  = err0_q;
    assign err1  = err1_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-schedule reference model plus a big-endian
// 128-byte memory, directed scenarios followed by randomized two-port traffic.
module tb_dmem_arbiter;

    localparam int unsigned MemBytes = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata, mem_Address, mem_WriteData, mem_ReadData;
    logic        mem_MemWrite, mem_MemRead;

    always #5 Clock = ~Clock;

    dmem_arbiter #(.MEM_BYTES(MemBytes)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .ack0          (ack0),
        .ack1          (ack1),
        .err0          (err0),
        .err1          (err1),
        .rdata         (rdata),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_ReadData  (mem_ReadData)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Data memory instance (not reset), combinational read, write on posedge.
    logic [7:0] mem [MemBytes];
    logic [7:0] ref_mem [MemBytes];

    always_comb begin
        mem_ReadData = 16'h0000;
        if (mem_Address < 16'(MemBytes - 1))
            mem_ReadData = {mem[mem_Address[6:0]], mem[mem_Address[6:0] + 7'd1]};
    end

    always @(posedge Clock) begin
        if (mem_MemWrite && mem_Address < 16'(MemBytes - 1)) begin
            mem[mem_Address[6:0]]        <= mem_WriteData[15:8];
            mem[mem_Address[6:0] + 7'd1] <= mem_WriteData[7:0];
        end
    end

    // Reference model: a grant taken at edge g drives memory after g, commits
    // and acks at g+1, and the arbiter samples requests again at g+3.
    int          edge_n  = 0;
    int          g_edge  = -100;
    int          idle_at = 0;
    bit          last    = 1'b1;
    bit          g_port, g_we;
    logic [15:0] g_addr  = 16'h0;
    logic [15:0] g_wdata = 16'h0;
    bit          model_valid = 1'b0;
    logic        e_ack0, e_ack1, e_err0, e_err1, e_wr, e_rd;
    logic [15:0] e_rdata, e_addr, e_wdata;
    bit          e_addr_chk, e_wdata_chk;

    always @(posedge Clock) begin : model
        bit          inr;
        logic [15:0] rd;
        edge_n = edge_n + 1;
        inr    = (g_addr <= 16'(MemBytes - 2));
        rd     = 16'h0000;
        if (edge_n == g_edge + 1 && inr) begin
            if (g_we) begin
                ref_mem[g_addr[6:0]]        = g_wdata[15:8];
                ref_mem[g_addr[6:0] + 7'd1] = g_wdata[7:0];
            end else begin
                rd = {ref_mem[g_addr[6:0]], ref_mem[g_addr[6:0] + 7'd1]};
            end
        end
        {e_ack0, e_ack1, e_err0, e_err1, e_wr, e_rd} = '0;
        e_rdata = 16'h0; e_addr = 16'h0; e_wdata = 16'h0;
        e_addr_chk = 1'b1; e_wdata_chk = 1'b1;
        if (Reset) begin
            idle_at     = edge_n + 1;
            last        = 1'b1;
            g_edge      = -100;
            model_valid = 1'b1;
        end else begin
            if (edge_n == g_edge + 1) begin
                e_ack0  = !g_port;
                e_ack1  = g_port;
                e_err0  = !g_port && !inr;
                e_err1  = g_port && !inr;
                e_rdata = rd;
            end
            if (edge_n == idle_at) begin
                if (req0 || req1) begin
                    g_port  = (req0 && req1) ? !last : req1;
                    last    = g_port;
                    g_we    = g_port ? we1 : we0;
                    g_addr  = g_port ? addr1 : addr0;
                    g_wdata = g_port ? wdata1 : wdata0;
                    g_edge  = edge_n;
                    idle_at = edge_n + 3;
                end else begin
                    idle_at = edge_n + 1;
                end
            end
            if (edge_n == g_edge) begin
                if (g_addr <= 16'(MemBytes - 2)) begin
                    e_addr  = g_addr;
                    e_wr    = g_we;
                    e_rd    = !g_we;
                    e_wdata = g_wdata;
                    e_wdata_chk = g_we;
                end else begin
                    e_addr_chk  = 1'b0;
                    e_wdata_chk = 1'b0;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (model_valid) begin
            chk("ack0", ack0, e_ack0);
            chk("ack1", ack1, e_ack1);
            chk("mem_MemWrite", mem_MemWrite, e_wr);
            chk("mem_MemRead", mem_MemRead, e_rd);
            if (e_ack0) chk("err0", err0, e_err0);
            if (e_ack1) chk("err1", err1, e_err1);
            if (e_ack0 || e_ack1) chk("rdata", rdata, e_rdata);
            if (e_addr_chk) chk("mem_Address", mem_Address, e_addr);
            if (e_wdata_chk) chk("mem_WriteData", mem_WriteData, e_wdata);
        end
    end

    int          wr_cycles = 0;
    logic [15:0] wr_addr   = 16'h0;
    always @(negedge Clock) begin
        if (mem_MemWrite) begin
            wr_cycles++;
            wr_addr = mem_Address;
        end
    end

    task automatic set_port(input bit p, input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    // Called right after a negedge; returns on the negedge where ack is seen.
    task automatic do_txn(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic er, output int lat);
        bit seen = 1'b0;
        set_port(p, 1'b1, w, a, d);
        lat = 0; rd = 16'hxxxx; er = 1'bx;
        while (!seen && lat < 20) begin
            @(negedge Clock);
            lat++;
            if (p ? ack1 : ack0) begin
                seen = 1'b1;
                rd   = rdata;
                er   = p ? err1 : err0;
            end
        end
        if (!seen) chk("txn ack timeout", 32'(lat), 32'd0);
        set_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 130));
    endfunction

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          wr0;
        logic [7:0]  b127;
        int          ack_t [$];
        bit          ack_p [$];
        int          both;
        int          idle_bad;
        int          diffs;

        Reset = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < int'(MemBytes); i++) begin
            mem[i]     <= 8'(i) ^ 8'h3C;
            ref_mem[i]  = 8'(i) ^ 8'h3C;
        end
        repeat (3) @(negedge Clock);
        chk("reset ack0", ack0, 0);
        chk("reset ack1", ack1, 0);
        chk("reset rdata", rdata, 0);
        chk("reset mem_Address", mem_Address, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Port 0 write 0xABCD to 0x0010.
        wr0 = wr_cycles;
        do_txn(1'b0, 1'b1, 16'h0010, 16'hABCD, rd, er, lat);
        chk("write latency", 32'(lat), 2);
        chk("write err0", er, 0);
        chk("write strobe cycles", 32'(wr_cycles - wr0), 1);
        chk("write strobe addr", wr_addr, 16'h0010);
        chk("mem[0x10]", mem[16], 8'hAB);
        chk("mem[0x11]", mem[17], 8'hCD);

        // Read back through port 1, then odd-address read through port 0.
        mem[18]     <= 8'h5A;
        ref_mem[18]  = 8'h5A;
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0, rd, er, lat);
        chk("read 0x10", rd, 16'hABCD);
        do_txn(1'b0, 1'b0, 16'h0011, 16'h0, rd, er, lat);
        chk("read 0x11", rd, 16'hCD5A);

        // Contention from a fresh reset (last_gnt = 1, so port 0 first).
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        set_port(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0);
        both = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clock);
            if (ack0 && ack1) both++;
            if (ack0) begin ack_t.push_back(c); ack_p.push_back(1'b0); end
            if (ack1) begin ack_t.push_back(c); ack_p.push_back(1'b1); end
        end
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("contention ack count", 32'(ack_t.size()), 4);
        chk("contention overlap", 32'(both), 0);
        if (ack_t.size() == 4) begin
            chk("contention order", {28'h0, ack_p[0], ack_p[1], ack_p[2], ack_p[3]}, 4'b0101);
            for (int i = 1; i < 4; i++) chk("contention spacing", 32'(ack_t[i] - ack_t[i-1]), 3);
        end
        repeat (3) @(negedge Clock);

        // Out-of-range writes on port 1.
        wr0  = wr_cycles;
        b127 = mem[127];
        do_txn(1'b1, 1'b1, 16'h007F, 16'h1234, rd, er, lat);
        chk("oor 0x7F err1", er, 1);
        chk("oor 0x7F rdata", rd, 0);
        do_txn(1'b1, 1'b1, 16'h0100, 16'h5678, rd, er, lat);
        chk("oor 0x100 err1", er, 1);
        chk("oor 0x100 rdata", rd, 0);
        chk("oor strobe cycles", 32'(wr_cycles - wr0), 0);
        chk("oor mem[0x7F]", mem[127], b127);

        // Reset on the ACCESS edge of a port 0 read, then the held request reissues.
        repeat (2) @(negedge Clock);
        set_port(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("abort ack0", ack0, 0);
        chk("abort rdata", rdata, 0);
        chk("abort mem_MemRead", mem_MemRead, 0);
        chk("abort mem_Address", mem_Address, 0);
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0, rd, er, lat);
        chk("reissued read", rd, 16'hABCD);
        chk("reissued latency", 32'(lat), 2);

        // Idle bus.
        idle_bad = 0;
        repeat (10) begin
            @(negedge Clock);
            if (ack0 || ack1 || mem_MemWrite || mem_MemRead || mem_Address != 16'h0 ||
                mem_WriteData != 16'h0) idle_bad++;
        end
        chk("idle bus activity", 32'(idle_bad), 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            Reset = ($urandom_range(0, 99) == 0);
            if (req0 && ack0) req0 = 1'b0;
            if (req1 && ack1) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0)
                set_port(1'b0, 1'b1, 1'($urandom), rand_addr(), 16'($urandom));
            if (!req1 && $urandom_range(0, 2) == 0)
                set_port(1'b1, 1'b1, 1'($urandom), rand_addr(), 16'($urandom));
        end
        @(negedge Clock);
        Reset = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (5) @(negedge Clock);

        diffs = 0;
        for (int i = 0; i < int'(MemBytes); i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("memory image", 32'(diffs), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
